// File: rtl/lsq_mem_arbiter.sv
// Arbitrates the single data-memory port between LSQ loads and committed stores.
// Loads win for latency; a wait counter lets a starved store through.
module lsq_mem_arbiter #(
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [ADDR_W-1:0] ld_req_addr,
  input  logic [31:0]       ld_req_tag,
  input  logic              st_req_valid,
  output logic              st_req_ready,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ld_resp_valid,
  output logic [31:0]       ld_resp_tag,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic              busy
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {StIdle, StRdWait} state_e;

  state_e            state_q, state_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [CntW-1:0]   st_wait_q, st_wait_d;
  logic              squash_q, squash_d;
  logic [31:0]       tag_q, tag_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_tag_q, resp_tag_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              ld_grant, st_grant, starved;

  assign starved = (st_wait_q >= CntW'(STARVE_LIMIT));

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    st_wait_d    = st_wait_q;
    squash_d     = squash_q;
    tag_d        = tag_q;
    resp_valid_d = 1'b0;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    ld_grant     = 1'b0;
    st_grant     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rstn) begin
          st_grant = st_req_valid && (!ld_req_valid || starved);
          ld_grant = ld_req_valid && !st_grant;
        end
        if (ld_grant) begin
          tag_d     = ld_req_tag;
          lat_cnt_d = LatW'(MEM_LAT - 1);
          squash_d  = flush;
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        if (lat_cnt_q == '0) begin
          // Read data lands this cycle; a flush now still suppresses the response.
          resp_valid_d = !squash_q && !flush;
          if (resp_valid_d) begin
            resp_tag_d  = tag_q;
            resp_data_d = mem_rdata;
          end
          squash_d = 1'b0;
          state_d  = StIdle;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
          if (flush) squash_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (st_grant) begin
      st_wait_d = '0;
    end else if (st_req_valid && !starved) begin
      st_wait_d = st_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= StIdle;
      lat_cnt_q    <= '0;
      st_wait_q    <= '0;
      squash_q     <= 1'b0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      st_wait_q    <= st_wait_d;
      squash_q     <= squash_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign ld_req_ready  = ld_grant;
  assign st_req_ready  = st_grant;
  assign mem_en        = ld_grant || st_grant;
  assign mem_we        = st_grant;
  assign mem_addr      = st_grant ? st_req_addr : ld_req_addr;
  assign mem_wdata     = st_grant ? st_req_data : '0;
  assign ld_resp_valid = resp_valid_q;
  assign ld_resp_tag   = resp_tag_q;
  assign ld_resp_data  = resp_data_q;
  assign busy          = (state_q == StRdWait);

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter: MEM_LAT=2 and MEM_LAT=1 instances share stimulus,
// load responses are checked against a scoreboard queue.
module tb_lsq_mem_arbiter;

  typedef struct packed {
    logic [31:0] tag;
    logic [7:0]  data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_req_valid, st_req_valid, flush;
  logic [9:0]  ld_req_addr, st_req_addr;
  logic [31:0] ld_req_tag;
  logic [7:0]  st_req_data;

  logic        ld_req_ready [2];
  logic        st_req_ready [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [9:0]  mem_addr [2];
  logic [7:0]  mem_wdata [2];
  logic [7:0]  mem_rdata [2];
  logic        ld_resp_valid [2];
  logic [31:0] ld_resp_tag [2];
  logic [7:0]  ld_resp_data [2];
  logic        busy [2];

  int          sel;
  int          n_checks = 0;
  int          n_err = 0;
  resp_t       sb[$];

  logic [9:0]  p1 [2];
  logic [9:0]  p2;

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_val(input logic [9:0] a);
    return a[7:0] ^ 8'hB7 ^ {a[9:8], 6'b0};
  endfunction

  lsq_mem_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4), .ADDR_W(10), .DATA_W(8)) u_lat2 (
    .clk(clk), .rstn(rstn),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready[0]),
    .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready[0]),
    .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .flush(flush),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .ld_resp_valid(ld_resp_valid[0]), .ld_resp_tag(ld_resp_tag[0]),
    .ld_resp_data(ld_resp_data[0]), .busy(busy[0])
  );

  lsq_mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4), .ADDR_W(10), .DATA_W(8)) u_lat1 (
    .clk(clk), .rstn(rstn),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready[1]),
    .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready[1]),
    .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .flush(flush),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .ld_resp_valid(ld_resp_valid[1]), .ld_resp_tag(ld_resp_tag[1]),
    .ld_resp_data(ld_resp_data[1]), .busy(busy[1])
  );

  // Memory model: read data appears MEM_LAT cycles after the address is issued.
  always_ff @(posedge clk) begin
    p1[0] <= mem_addr[0];
    p2    <= p1[0];
    p1[1] <= mem_addr[1];
  end
  assign mem_rdata[0] = rd_val(p2);
  assign mem_rdata[1] = rd_val(p1[1]);

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push_ld();
    sb.push_back('{tag: ld_req_tag, data: rd_val(ld_req_addr)});
  endtask

  always @(negedge clk) begin
    if (ld_resp_valid[sel]) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL resp_unexpected: observed tag %0h expected no response", ld_resp_tag[sel]);
      end
      if (sb.size() != 0) begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_tag", 64'(ld_resp_tag[sel]), 64'(e.tag));
        chk("resp_data", 64'(ld_resp_data[sel]), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_ld;
    logic [7:0] exp_st;
    sel = 0;
    rstn = 1'b1;
    ld_req_valid = 1'b1; st_req_valid = 1'b1; flush = 1'b0;
    ld_req_addr = '0; ld_req_tag = '0; st_req_addr = '0; st_req_data = '0;
    adv();
    adv();
    smp();
    chk("rst_ld_rdy", 64'(ld_req_ready[0]), 0);
    chk("rst_st_rdy", 64'(st_req_ready[0]), 0);
    chk("rst_mem_en", 64'(mem_en[0]), 0);
    chk("rst_busy", 64'(busy[0]), 0);
    chk("rst_resp_valid", 64'(ld_resp_valid[0]), 0);
    chk("rst_resp_tag", 64'(ld_resp_tag[0]), 0);
    adv();
    rstn = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
    adv();

    // Single load, MEM_LAT=2
    ld_req_valid = 1'b1; ld_req_addr = 10'h012; ld_req_tag = 32'h40;
    smp();
    chk("ld_rdy_c0", 64'(ld_req_ready[0]), 1);
    chk("ld_mem_en", 64'(mem_en[0]), 1);
    chk("ld_mem_we", 64'(mem_we[0]), 0);
    chk("ld_mem_addr", 64'(mem_addr[0]), 64'h012);
    push_ld();
    for (int c = 1; c <= 2; c++) begin
      adv();
      smp();
      chk("ld_wait_rdy", 64'(ld_req_ready[0]), 0);
      chk("ld_wait_busy", 64'(busy[0]), 1);
      chk("ld_wait_mem_en", 64'(mem_en[0]), 0);
      chk("ld_wait_resp", 64'(ld_resp_valid[0]), 0);
    end
    adv();
    ld_req_valid = 1'b0;
    smp();
    chk("ld_resp_c3", 64'(ld_resp_valid[0]), 1);
    chk("ld_resp_c3_data", 64'(ld_resp_data[0]), 64'hA5);
    chk("ld_idle_busy", 64'(busy[0]), 0);
    adv();

    // Back-to-back stores at address extremes
    st_req_valid = 1'b1; st_req_addr = 10'h3FF; st_req_data = 8'h5C;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk("st_rdy", 64'(st_req_ready[0]), 1);
      chk("st_mem_en", 64'(mem_en[0]), 1);
      chk("st_mem_we", 64'(mem_we[0]), 1);
      chk("st_mem_addr", 64'(mem_addr[0]), 64'(st_req_addr));
      chk("st_mem_wdata", 64'(mem_wdata[0]), 64'(st_req_data));
      chk("st_busy", 64'(busy[0]), 0);
      adv();
      st_req_addr = 10'h000; st_req_data = 8'hC5;
    end
    st_req_valid = 1'b0;

    // Starvation: loads at 0,3, store at 6, load at 7
    exp_ld = 8'b1000_1001;
    exp_st = 8'b0100_0000;
    ld_req_valid = 1'b1; ld_req_addr = 10'h020; ld_req_tag = 32'h100;
    st_req_valid = 1'b1; st_req_addr = 10'h155; st_req_data = 8'h3C;
    for (int c = 0; c < 8; c++) begin
      smp();
      chk("starve_ld_rdy", 64'(ld_req_ready[0]), 64'(exp_ld[c]));
      chk("starve_st_rdy", 64'(st_req_ready[0]), 64'(exp_st[c]));
      if (exp_ld[c]) push_ld();
      if (c == 6) begin
        chk("starve_st_we", 64'(mem_we[0]), 1);
        chk("starve_st_addr", 64'(mem_addr[0]), 64'h155);
        chk("starve_st_wdata", 64'(mem_wdata[0]), 64'h3C);
      end
      if (c == 7) chk("starve_cnt_clr", 64'(u_lat2.st_wait_q), 0);
      adv();
      if (exp_ld[c]) begin
        ld_req_addr = ld_req_addr + 10'd4;
        ld_req_tag  = ld_req_tag + 32'd4;
      end
    end
    ld_req_valid = 1'b0; st_req_valid = 1'b0;
    smp();
    chk("starve_tail_busy", 64'(busy[0]), 1);
    adv(); adv(); adv();

    // Flush squashes in-flight load; next load responds normally
    ld_req_valid = 1'b1; ld_req_addr = 10'h031; ld_req_tag = 32'h200;
    smp();
    chk("fl_rdy_c0", 64'(ld_req_ready[0]), 1);
    adv();
    ld_req_valid = 1'b0; flush = 1'b1;
    adv();
    flush = 1'b0;
    adv();
    ld_req_valid = 1'b1; ld_req_addr = 10'h032; ld_req_tag = 32'h204;
    smp();
    chk("fl_no_resp_c3", 64'(ld_resp_valid[0]), 0);
    chk("fl_rdy_c3", 64'(ld_req_ready[0]), 1);
    push_ld();
    adv();
    ld_req_valid = 1'b0;
    adv(); adv();
    smp();
    chk("fl_resp_c6", 64'(ld_resp_valid[0]), 1);
    adv();

    // Reset mid-read
    ld_req_valid = 1'b1; ld_req_addr = 10'h077; ld_req_tag = 32'h300;
    smp();
    chk("rr_rdy_c0", 64'(ld_req_ready[0]), 1);
    adv();
    ld_req_valid = 1'b0; rstn = 1'b1;
    adv();
    st_req_valid = 1'b1; st_req_addr = 10'h0AA; st_req_data = 8'h11;
    smp();
    chk("rr_busy_c2", 64'(busy[0]), 0);
    chk("rr_resp_c2", 64'(ld_resp_valid[0]), 0);
    chk("rr_mem_en_c2", 64'(mem_en[0]), 0);
    chk("rr_st_rdy_c2", 64'(st_req_ready[0]), 0);
    adv();
    rstn = 1'b0;
    smp();
    chk("rr_st_rdy_c3", 64'(st_req_ready[0]), 1);
    chk("rr_resp_c3", 64'(ld_resp_valid[0]), 0);
    adv();
    st_req_valid = 1'b0;
    smp();
    chk("rr_resp_c4", 64'(ld_resp_valid[0]), 0);
    adv();

    // MEM_LAT=1 instance, back-to-back loads
    rstn = 1'b1;
    adv();
    rstn = 1'b0;
    sel = 1;
    ld_req_valid = 1'b1; ld_req_addr = 10'h041; ld_req_tag = 32'h4;
    smp();
    chk("l1_rdy_c0", 64'(ld_req_ready[1]), 1);
    push_ld();
    adv();
    ld_req_addr = 10'h042; ld_req_tag = 32'h8;
    smp();
    chk("l1_rdy_c1", 64'(ld_req_ready[1]), 0);
    chk("l1_busy_c1", 64'(busy[1]), 1);
    adv();
    smp();
    chk("l1_rdy_c2", 64'(ld_req_ready[1]), 1);
    chk("l1_resp_c2", 64'(ld_resp_valid[1]), 1);
    push_ld();
    adv();
    ld_req_valid = 1'b0;
    smp();
    chk("l1_resp_c3", 64'(ld_resp_valid[1]), 0);
    adv();
    smp();
    chk("l1_resp_c4", 64'(ld_resp_valid[1]), 1);
    adv();
    adv();

    n_checks++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drained: observed %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lsq_mem_arbiter.md
Name: lsq_mem_arbiter

Overview:
- Sequences the single data-memory port between two requesters.
- Requester 1: load requests issued by the LSQ once the LSU has resolved the address.
- Requester 2: store commits released by the LSQ at in-order retirement.
- Loads have priority for latency; a starvation counter guarantees store forward progress.
- Reads are blocking with a fixed memory latency; read responses carry the load's PC tag back to the LSQ.
- A flush squashes the response of an in-flight speculative load.

Parameters:
MEM_LAT, 2, data-memory read latency in cycles (>=1)
STARVE_LIMIT, 4, store wait-cycles after which a store beats a pending load (>=1)
ADDR_W, 10, memory address width
DATA_W, 8, memory data width

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  synchronous active-high reset (port name kept per codebase; asserted = 1)
ld_req_valid  input  1  load request pending
ld_req_ready  output  1  load accepted this cycle
ld_req_addr  input  ADDR_W  load address
ld_req_tag  input  32  load PC tag
st_req_valid  input  1  committed store pending
st_req_ready  output  1  store accepted this cycle
st_req_addr  input  ADDR_W  store address
st_req_data  input  DATA_W  store data
flush  input  1  squash in-flight load response
mem_en  output  1  memory access this cycle
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  write data
mem_rdata  input  DATA_W  read data, valid MEM_LAT cycles after read issue
ld_resp_valid  output  1  one-cycle load response pulse
ld_resp_tag  output  32  PC of responding load
ld_resp_data  output  DATA_W  loaded data
busy  output  1  read in flight (state RD_WAIT)

Behaviour:
Reset:
- Synchronous reset takes priority over all other activity, including mid-operation.
- Reset values: state = IDLE, lat_cnt = 0, st_wait_cnt = 0, squash = 0, ld_resp_valid/tag/data = 0.
- While rstn = 1, both readys and mem_en are forced to 0.

State machine (states IDLE, RD_WAIT):
- Grant is computed only in IDLE:
  - Only one requester valid: it is granted.
  - Both valid: store is granted if st_wait_cnt >= STARVE_LIMIT, else load.
- Readys are combinational from grant. Requesters must not make valid depend on ready.
- Store grant:
  - Same cycle: mem_en = 1, mem_we = 1, mem_addr/mem_wdata = store fields.
  - State stays IDLE, so back-to-back stores run at 1 per cycle.
- Load grant:
  - Same cycle: mem_en = 1, mem_we = 0, mem_addr = ld_req_addr.
  - ld_req_tag is latched; lat_cnt is loaded with MEM_LAT - 1.
  - Next state is RD_WAIT.
- RD_WAIT:
  - Both readys = 0 and mem_en = 0.
  - lat_cnt decrements each cycle. In the cycle where lat_cnt = 0, mem_rdata is sampled and the state returns to IDLE.
  - ld_resp_valid pulses in the following cycle with the latched tag and data, unless squash is set.
  - A new request may be accepted in the same cycle as ld_resp_valid.
  - Total load latency is MEM_LAT + 1 cycles from acceptance to response.
  - With MEM_LAT = 1, RD_WAIT lasts exactly one cycle.
- st_wait_cnt:
  - Increments (saturating at STARVE_LIMIT) at the end of each cycle with st_req_valid = 1 and no store accept, including cycles spent in RD_WAIT.
  - Clears on store accept.
- flush:
  - In RD_WAIT, or in the same cycle as a load accept: sets squash. The memory read still completes, no response is emitted, and squash clears when the state returns to IDLE.
  - In the sample cycle: the response is suppressed.
  - In IDLE with no load accept: no effect.
  - Stores are never affected.
- busy = (state == RD_WAIT).

Test Plan:
- MEM_LAT = 2, load addr 0x012 tag 0x40 accepted cycle 0, mem_rdata = 0xA5 in cycle 2 -> ld_resp_valid = 1 in cycle 3 with tag 0x40 and data 0xA5; ld_req_ready = 0 in cycles 1-2; busy = 1 in cycles 1-2.
- Stores only: addr 0x3FF/0x000 with data 0x5C/0xC5 on consecutive cycles -> each cycle st_req_ready = 1, mem_en = 1, mem_we = 1 with matching addr/data; never busy.
- MEM_LAT = 2, STARVE_LIMIT = 4, both valid continuously from cycle 0:
  - Loads are granted in cycles 0 and 3.
  - The store is granted in cycle 6, and st_wait_cnt = 0 in cycle 7.
  - A load is granted in cycle 7.
- Load accepted cycle 0 (MEM_LAT = 2), flush = 1 in cycle 1 -> no ld_resp_valid in cycle 3; a load presented in cycle 3 is accepted in cycle 3 and responds normally in cycle 6.
- Load accepted cycle 0, rstn = 1 in cycle 1 -> outputs are 0 from cycle 2; no ld_resp_valid ever; after reset release a store is accepted on its first valid cycle.
- MEM_LAT = 1, back-to-back loads tags 0x4 and 0x8 -> accepts in cycles 0 and 2; responses in cycles 2 and 4 with the correct tags and data.
